// File: rtl/rot_column_scanner.sv
// rot_column_scanner: tracks rotor angle from a once-per-revolution hall pulse,
// fetches the theta / theta+pi column pair each angular step and shifts both
// columns serially into two LED-driver chains, then latches them with radii.
module rot_column_scanner #(
    parameter int unsigned ROTATIONAL_RES = 1024,
    parameter int unsigned DISPLAY_RADIUS = 32,
    parameter int unsigned DISPLAY_HEIGHT = 64,
    parameter int unsigned DATA_SIZE      = 1,
    parameter int unsigned PERIOD_W       = 28,
    parameter int unsigned MIN_PERIOD     = 1000,
    parameter int unsigned SCLK_HALF      = 2,
    parameter int unsigned READ_LATENCY   = 2
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic                                         hall_in,
    input  logic                                         fb_busy,
    output logic [$clog2(ROTATIONAL_RES)-1:0]            theta_read,
    input  logic [1:0][DISPLAY_HEIGHT*DATA_SIZE-1:0]     columns_in,
    input  logic [1:0][$clog2(DISPLAY_RADIUS)-1:0]       radii_in,
    output logic [1:0]                                   sdata_out,
    output logic                                         sclk_out,
    output logic                                         latch_out,
    output logic [1:0][$clog2(DISPLAY_RADIUS)-1:0]       radius_out,
    output logic                                         blank_out,
    output logic                                         stalled,
    output logic [15:0]                                  overrun_count
);

    localparam int unsigned TW  = $clog2(ROTATIONAL_RES);
    localparam int unsigned RW  = $clog2(DISPLAY_RADIUS);
    localparam int unsigned CW  = DISPLAY_HEIGHT * DATA_SIZE;
    localparam int unsigned BCW = (CW > 1) ? $clog2(CW) : 1;
    localparam int unsigned HCW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int unsigned RCW = $clog2(READ_LATENCY + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    // rotor tracking state
    logic                hall_s1_q, hall_s2_q, hall_s3_q, hall_edge_q;
    logic                first_q, first_d;
    logic                seen_q, seen_d;
    logic                stalled_q, stalled_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [PERIOD_W-1:0] step_len_q, step_len_d;
    logic [PERIOD_W-1:0] step_cnt_q, step_cnt_d;
    logic [PERIOD_W-1:0] period_shift_c;
    logic [TW-1:0]       theta_q, theta_d;
    logic                accept_c, advance_c, step_evt_c, period_sat_c;

    // scan state
    logic [1:0]             state_q, state_d;
    logic [RCW-1:0]         wait_q, wait_d;
    logic [HCW-1:0]         half_q, half_d;
    logic [BCW-1:0]         bit_q, bit_d;
    logic [1:0][CW-1:0]     sh_q, sh_d;
    logic [1:0][RW-1:0]     rad_q, rad_d;
    logic [TW-1:0]          theta_read_q, theta_read_d;
    logic [1:0]             sdata_q, sdata_d;
    logic                   sclk_q, sclk_d;
    logic                   latch_q, latch_d;
    logic [1:0][RW-1:0]     radius_q, radius_d;
    logic [15:0]            ovr_q, ovr_d;

    // Hall acceptance, period measurement, angular stepping and stall detection
    always_comb begin
        first_d        = first_q;
        seen_d         = seen_q;
        stalled_d      = stalled_q;
        period_cnt_d   = period_cnt_q;
        step_len_d     = step_len_q;
        step_cnt_d     = step_cnt_q + PERIOD_W'(1);
        theta_d        = theta_q;
        period_shift_c = period_cnt_q >> TW;
        period_sat_c   = (period_cnt_q == {PERIOD_W{1'b1}});
        accept_c       = hall_edge_q && (first_q || (period_cnt_q >= PERIOD_W'(MIN_PERIOD)));
        advance_c      = !accept_c && (step_cnt_q == (step_len_q - PERIOD_W'(1)))
                         && (theta_q != TW'(ROTATIONAL_RES - 1));

        if (!period_sat_c) begin
            period_cnt_d = period_cnt_q + PERIOD_W'(1);
        end

        if (accept_c) begin
            period_cnt_d = '0;
            step_cnt_d   = '0;
            theta_d      = '0;
            step_len_d   = (period_shift_c == '0) ? PERIOD_W'(1) : period_shift_c;
            first_d      = 1'b0;
            seen_d       = 1'b1;
            if (seen_q) begin
                stalled_d = 1'b0;
            end
        end else begin
            if (advance_c) begin
                theta_d    = theta_q + TW'(1);
                step_cnt_d = '0;
            end
            if (period_sat_c) begin
                stalled_d = 1'b1;
                seen_d    = 1'b0;
            end
        end

        step_evt_c = (accept_c || advance_c) && !stalled_d;
    end

    // Scan FSM: fetch column pair, serialize both chains, strobe the latch
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        half_d       = half_q;
        bit_d        = bit_q;
        sh_d         = sh_q;
        rad_d        = rad_q;
        theta_read_d = theta_read_q;
        sdata_d      = sdata_q;
        sclk_d       = sclk_q;
        latch_d      = latch_q;
        radius_d     = radius_q;
        ovr_d        = ovr_q;

        if (step_evt_c && (state_q != S_IDLE) && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (step_evt_c) begin
                    theta_read_d = theta_d;
                    wait_d       = '0;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                if (wait_q == RCW'(READ_LATENCY)) begin
                    wait_d = '0;
                    if (!fb_busy) begin
                        for (int k = 0; k < 2; k++) begin
                            sdata_d[k] = columns_in[k][CW-1];
                            sh_d[k]    = columns_in[k] << 1;
                        end
                        rad_d   = radii_in;
                        sclk_d  = 1'b0;
                        half_d  = '0;
                        bit_d   = '0;
                        state_d = S_SHIFT;
                    end
                end else begin
                    wait_d = wait_q + RCW'(1);
                end
            end
            S_SHIFT: begin
                if (half_q == HCW'(SCLK_HALF - 1)) begin
                    half_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BCW'(CW - 1)) begin
                            sdata_d  = '0;
                            latch_d  = 1'b1;
                            radius_d = rad_q;
                            state_d  = S_LATCH;
                        end else begin
                            bit_d = bit_q + BCW'(1);
                            for (int k = 0; k < 2; k++) begin
                                sdata_d[k] = sh_q[k][CW-1];
                                sh_d[k]    = sh_q[k] << 1;
                            end
                        end
                    end
                end else begin
                    half_d = half_q + HCW'(1);
                end
            end
            S_LATCH: begin
                if (half_q == HCW'(SCLK_HALF - 1)) begin
                    half_d  = '0;
                    latch_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    half_d = half_q + HCW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hall_s1_q    <= 1'b0;
            hall_s2_q    <= 1'b0;
            hall_s3_q    <= 1'b0;
            hall_edge_q  <= 1'b0;
            first_q      <= 1'b1;
            seen_q       <= 1'b0;
            stalled_q    <= 1'b1;
            period_cnt_q <= '0;
            step_len_q   <= PERIOD_W'(1);
            step_cnt_q   <= '0;
            theta_q      <= '0;
            state_q      <= S_IDLE;
            wait_q       <= '0;
            half_q       <= '0;
            bit_q        <= '0;
            sh_q         <= '0;
            rad_q        <= '0;
            theta_read_q <= '0;
            sdata_q      <= '0;
            sclk_q       <= 1'b0;
            latch_q      <= 1'b0;
            radius_q     <= '0;
            ovr_q        <= '0;
        end else begin
            hall_s1_q    <= hall_in;
            hall_s2_q    <= hall_s1_q;
            hall_s3_q    <= hall_s2_q;
            hall_edge_q  <= hall_s2_q && !hall_s3_q;
            first_q      <= first_d;
            seen_q       <= seen_d;
            stalled_q    <= stalled_d;
            period_cnt_q <= period_cnt_d;
            step_len_q   <= step_len_d;
            step_cnt_q   <= step_cnt_d;
            theta_q      <= theta_d;
            state_q      <= state_d;
            wait_q       <= wait_d;
            half_q       <= half_d;
            bit_q        <= bit_d;
            sh_q         <= sh_d;
            rad_q        <= rad_d;
            theta_read_q <= theta_read_d;
            sdata_q      <= sdata_d;
            sclk_q       <= sclk_d;
            latch_q      <= latch_d;
            radius_q     <= radius_d;
            ovr_q        <= ovr_d;
        end
    end

    assign theta_read    = theta_read_q;
    assign sdata_out     = sdata_q;
    assign sclk_out      = sclk_q;
    assign latch_out     = latch_q;
    assign radius_out    = radius_q;
    assign stalled       = stalled_q;
    assign blank_out     = stalled_q;
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_rot_column_scanner.sv
// Directed bench for rot_column_scanner with a reduced geometry:
// 16 steps/rev, 8-LED columns, 12-bit period counter, MIN_PERIOD 100.
module tb_rot_column_scanner;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             hall_in;
    logic             fb_busy;
    logic [3:0]       theta_read;
    logic [1:0][7:0]  columns_in;
    logic [1:0][4:0]  radii_in;
    logic [1:0]       sdata_out;
    logic             sclk_out;
    logic             latch_out;
    logic [1:0][4:0]  radius_out;
    logic             blank_out;
    logic             stalled;
    logic [15:0]      overrun_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] th;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [4:0] r0;
        logic [4:0] r1;
        int         nbits;
        int         cyc;
    } frame_t;

    frame_t     fq[$];
    frame_t     fr;
    logic [7:0] sh0 = 8'h00;
    logic [7:0] sh1 = 8'h00;
    int         nbits = 0;
    logic [3:0] p1, p2;

    rot_column_scanner #(
        .ROTATIONAL_RES(16), .DISPLAY_RADIUS(32), .DISPLAY_HEIGHT(8), .DATA_SIZE(1),
        .PERIOD_W(12), .MIN_PERIOD(100), .SCLK_HALF(2), .READ_LATENCY(2)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hall_in(hall_in), .fb_busy(fb_busy),
        .theta_read(theta_read), .columns_in(columns_in), .radii_in(radii_in),
        .sdata_out(sdata_out), .sclk_out(sclk_out), .latch_out(latch_out),
        .radius_out(radius_out), .blank_out(blank_out), .stalled(stalled),
        .overrun_count(overrun_count)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [7:0] col0(input logic [3:0] t);
        return (t == 4'd0) ? 8'h81 : {4'h5, t};
    endfunction
    function automatic logic [7:0] col1(input logic [3:0] t);
        return (t == 4'd0) ? 8'h00 : {t, 4'hA};
    endfunction
    function automatic logic [4:0] rad0(input logic [3:0] t);
        return (t == 4'd0) ? 5'd5 : {1'b0, t};
    endfunction
    function automatic logic [4:0] rad1(input logic [3:0] t);
        return (t == 4'd0) ? 5'd9 : (5'd31 - {1'b0, t});
    endfunction

    // Frame buffer model: two-cycle read pipeline; data is corrupted while busy
    always @(posedge clk_in) begin
        p1 <= theta_read;
        p2 <= p1;
    end
    always_comb begin
        columns_in[0] = col0(p2) ^ {8{fb_busy}};
        columns_in[1] = col1(p2) ^ {8{fb_busy}};
        radii_in[0]   = rad0(p2);
        radii_in[1]   = rad1(p2);
    end

    // Driver-chain model: shift on sclk rise, record a frame on latch rise
    always @(posedge sclk_out or posedge latch_out) begin
        if (latch_out) begin
            #1;
            fr.th    = theta_read;
            fr.w0    = sh0;
            fr.w1    = sh1;
            fr.r0    = radius_out[0];
            fr.r1    = radius_out[1];
            fr.nbits = nbits;
            fr.cyc   = cyc;
            fq.push_back(fr);
            nbits = 0;
        end else begin
            sh0   = {sh0[6:0], sdata_out[0]};
            sh1   = {sh1[6:0], sdata_out[1]};
            nbits = nbits + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hall_pulse_gap(input int gap);
        hall_in = 1'b1;
        repeat (4) @(negedge clk_in);
        hall_in = 1'b0;
        repeat (gap - 4) @(negedge clk_in);
    endtask

    task automatic check_rev(input string nm, input int n_exp, input int th_step,
                             input int delta, input bit busy_rev);
        int exp_d;
        logic [3:0] th;
        check_val({nm, "_count"}, fq.size(), n_exp);
        for (int i = 0; i < fq.size() && i < n_exp; i++) begin
            th = 4'(i * th_step);
            check_val($sformatf("%s_f%0d_theta", nm, i), fq[i].th, th);
            check_val($sformatf("%s_f%0d_w0", nm, i), fq[i].w0, col0(th));
            check_val($sformatf("%s_f%0d_w1", nm, i), fq[i].w1, col1(th));
            check_val($sformatf("%s_f%0d_r0", nm, i), fq[i].r0, rad0(th));
            check_val($sformatf("%s_f%0d_r1", nm, i), fq[i].r1, rad1(th));
            check_val($sformatf("%s_f%0d_bits", nm, i), fq[i].nbits, 8);
            if (i > 0) begin
                exp_d = delta;
                if (busy_rev && i == 5) exp_d = delta + 18;
                if (busy_rev && i == 6) exp_d = delta - 18;
                check_val($sformatf("%s_f%0d_spacing", nm, i), fq[i].cyc - fq[i-1].cyc, exp_d);
            end
        end
        fq.delete();
    endtask

    initial begin
        rst_in  = 1'b1;
        hall_in = 1'b0;
        fb_busy = 1'b0;
        repeat (3) @(negedge clk_in);
        check_val("rst_theta_read", theta_read, 0);
        check_val("rst_sdata", sdata_out, 0);
        check_val("rst_sclk", sclk_out, 0);
        check_val("rst_latch", latch_out, 0);
        check_val("rst_radius", radius_out, 0);
        check_val("rst_overrun", overrun_count, 0);
        check_val("rst_stalled", stalled, 1);
        check_val("rst_blank", blank_out, 1);
        rst_in = 1'b0;
        repeat (10) @(negedge clk_in);

        // First edge after reset: accepted but the rotor is still stalled
        hall_pulse_gap(1600);
        check_val("edge1_stalled", stalled, 1);
        check_val("edge1_no_frames", fq.size(), 0);

        // Second edge: period 1600 -> step_len 99, full revolution of frames
        hall_pulse_gap(1600);
        check_val("edge2_stalled", stalled, 0);
        check_val("edge2_blank", blank_out, 0);
        check_rev("rev2", 16, 1, 99, 1'b0);

        // Glitch 50 cycles after an edge, and fb_busy across the theta 5 sample
        fork
            begin
                hall_pulse_gap(50);
                hall_pulse_gap(1550);
            end
            begin
                for (int n = 0; n < 2000 && theta_read != 4'd5; n++) @(negedge clk_in);
                check_val("busy_theta_found", theta_read, 5);
                fb_busy = 1'b1;
                repeat (19) @(negedge clk_in);
                check_val("retry_theta", theta_read, 5);
                check_val("retry_no_latch", latch_out, 0);
                @(negedge clk_in);
                fb_busy = 1'b0;
            end
        join
        check_val("rev3_overrun", overrun_count, 0);
        check_rev("rev3", 16, 1, 99, 1'b1);

        // Short revolution cut by the next edge; no collision yet
        hall_pulse_gap(450);
        check_val("rev4_overrun", overrun_count, 0);
        check_rev("rev4", 5, 1, 99, 1'b0);

        // step_len 28 < frame length 37: every odd step is dropped
        hall_pulse_gap(450);
        check_val("rev5_overrun", overrun_count, 8);
        check_rev("rev5", 8, 2, 28 * 2, 1'b0);

        // Last edge, then the hall stops and the period counter saturates
        hall_pulse_gap(4);
        repeat (3990) @(negedge clk_in);
        check_val("pre_stall", stalled, 0);
        check_val("rev6_overrun", overrun_count, 16);
        check_rev("rev6", 8, 2, 28 * 2, 1'b0);
        repeat (200) @(negedge clk_in);
        check_val("stall_stalled", stalled, 1);
        check_val("stall_blank", blank_out, 1);

        // Re-arm after stall needs two edges
        hall_pulse_gap(1600);
        check_val("rearm1_stalled", stalled, 1);
        check_val("rearm1_no_frames", fq.size(), 0);
        hall_pulse_gap(4);
        for (int n = 0; n < 100 && sclk_out !== 1'b1; n++) @(negedge clk_in);
        check_val("rearm2_sclk", sclk_out, 1);
        check_val("rearm2_stalled", stalled, 0);

        // Reset in the middle of a frame
        rst_in = 1'b1;
        @(negedge clk_in);
        check_val("midrst_sclk", sclk_out, 0);
        check_val("midrst_latch", latch_out, 0);
        check_val("midrst_sdata", sdata_out, 0);
        check_val("midrst_theta_read", theta_read, 0);
        check_val("midrst_stalled", stalled, 1);
        check_val("midrst_blank", blank_out, 1);
        check_val("midrst_overrun", overrun_count, 0);
        rst_in = 1'b0;
        repeat (50) @(negedge clk_in);
        check_val("post_rst_latch", latch_out, 0);
        check_val("post_rst_frames", fq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rot_column_scanner.md
# rot_column_scanner

Downstream consumer of the rotational frame buffer. Tracks spinning-arm angle from a once-per-revolution hall pulse and divides each measured revolution into ROTATIONAL_RES angular steps. At every step it reads the column pair (theta and theta+pi) from the buffer, then shifts both columns serially into the two LED-driver chains and latches them together with their radii. It also reports a stalled rotor and any angular steps it has dropped.

## Interface
Parameters:
- ROTATIONAL_RES, 1024: angular steps per revolution; power of two.
- DISPLAY_RADIUS, 32: radius positions; radii are $clog2(DISPLAY_RADIUS) bits wide.
- DISPLAY_HEIGHT, 64: LEDs per column.
- DATA_SIZE, 1: bits per LED; column width is CW = DISPLAY_HEIGHT*DATA_SIZE.
- PERIOD_W, 28: width of the revolution-period counter.
- MIN_PERIOD, 1000: hall edges closer than this many cycles to the last accepted edge are ignored.
- SCLK_HALF, 2: cycles per sclk half-period; must be at least 1.
- READ_LATENCY, 2: cycles from theta_read to valid columns_in.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; synchronous, active-high.
- hall_in  in  1  asynchronous hall sensor; a rising edge marks theta = 0.
- fb_busy  in  1  frame buffer busy (flush or write); column data is invalid while high.
- theta_read  out  $clog2(ROTATIONAL_RES)  read address to the frame buffer.
- columns_in  in  [1:0][CW-1:0]  columns at theta and theta+pi.
- radii_in  in  [1:0][$clog2(DISPLAY_RADIUS)-1:0]  radii of those columns.
- sdata_out  out  [1:0]  serial data for chain 0 and chain 1.
- sclk_out  out  1  shift clock shared by both chains.
- latch_out  out  1  driver latch strobe.
- radius_out  out  [1:0][$clog2(DISPLAY_RADIUS)-1:0]  radii of the currently latched columns.
- blank_out  out  1  driver output-enable inhibit.
- stalled  out  1  no valid revolution period is available.
- overrun_count  out  16  number of dropped steps; saturates.

## Operation
- Hall input: passes through a 2-flop synchronizer, then rising-edge detection.
  - An edge is accepted only if period_cnt >= MIN_PERIOD, or if it is the first edge after reset.
- period_cnt increments every cycle and saturates at all-ones.
- On an accepted edge:
  - step_len <= max(1, period_cnt >> $clog2(ROTATIONAL_RES)).
  - period_cnt <= 0; theta <= 0; step_cnt <= 0.
  - A new_step pulse is issued.
  - stalled clears only if this is at least the second accepted edge since reset or since the last stall.
- Stepping: step_cnt increments each cycle. When step_cnt == step_len-1 and theta < ROTATIONAL_RES-1: theta++, step_cnt <= 0, new_step pulse.
  - theta holds at ROTATIONAL_RES-1 until the next accepted edge; there is no wrap without a hall edge.
- Stall: when period_cnt saturates, stalled <= 1 and blank_out <= 1. new_step pulses are suppressed while stalled.
- Scan FSM states are IDLE, READ, SHIFT, LATCH.
  - IDLE: on new_step, theta_read <= theta and go to READ.
  - READ: wait READ_LATENCY+1 cycles, then sample fb_busy.
    - If fb_busy is high, restart READ with the same theta_read (retry).
    - Otherwise capture columns_in and radii_in into shift registers and go to SHIFT.
  - SHIFT: shift CW bits per chain, bit CW-1 first. sdata_out[k] comes from captured column k. Then go to LATCH.
  - LATCH: latch_out is high for SCLK_HALF cycles. radius_out loads the captured radii on the cycle latch_out rises. Return to IDLE.
- A new_step while the FSM is not IDLE increments overrun_count, saturating at 16'hFFFF. That step is dropped; the in-flight frame completes.
- blank_out = stalled.

## Timing
- Reset values: theta_read = 0, sdata_out = 0, sclk_out = 0, latch_out = 0, radius_out = 0, overrun_count = 0, stalled = 1, blank_out = 1. FSM is in IDLE and period_cnt = 0.
- Reset asserted mid-frame aborts the frame; all outputs return to reset values on the next edge.
- An accepted hall edge is seen 3 cycles after hall_in rises: 2 cycles of sync plus 1 of edge detect.
- The new_step pulse and theta_read update are registered 1 cycle after the step event.
- Bit timing: sdata_out changes with sclk_out low. sclk_out is low for SCLK_HALF cycles, then high for SCLK_HALF cycles. sclk_out is low again before latch_out rises.
- Frame length with no retry: (READ_LATENCY+1) + 2*SCLK_HALF*CW + SCLK_HALF cycles. With defaults this is 3 + 256 + 2 = 261.
- step_len must be at least the frame length to avoid overruns.
- If new_step and an accepted hall edge fall in the same cycle, the hall edge wins: theta = 0.

## Test plan
- Reset, then a hall pulse every 300000 cycles -> stalled clears after the 2nd edge; step_len = 292; theta_read steps 0 to 1023 every 292 cycles.
- Buffer model returning columns 64'h8000_0000_0000_0001 / 64'h0 with radii 5 / 9 -> chain 0 serializes 1, 62 zeros, 1; chain 1 all zeros; radius_out = {9,5} at the latch_out rise.
- Hall edges 100000 cycles apart (step_len = 97 < 261) -> overrun_count increments on each colliding step; each frame still completes intact.
- fb_busy held high for 20 cycles across the capture sample -> READ retries the same theta_read; the capture happens after fb_busy falls; no overrun is counted if the retry fits in step_len.
- Hall stopped -> stalled = 1 and blank_out = 1 after period_cnt saturates (2^28-1 cycles); with PERIOD_W = 12, this happens after 4095 cycles.
- Hall glitch 500 cycles after an accepted edge -> ignored; theta is not reset and step_len is unchanged.
